// File: rtl/gray_counter_arbiter.sv
// Round-robin arbiter sharing one gray counter between two requesters.
// Each requester has a 2-entry command FIFO and gets its own result indication.
module gray_counter_arbiter #(
  parameter int unsigned Width = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             req0_ena,
  input  logic [1:0]       req0_op,
  input  logic [Width-1:0] req0_v,
  output logic             req0_rdy,
  input  logic             req1_ena,
  input  logic [1:0]       req1_op,
  input  logic [Width-1:0] req1_v,
  output logic             req1_rdy,
  output logic             ind0_ena,
  output logic [Width-1:0] ind0_gray,
  output logic [Width-1:0] ind0_bin,
  input  logic             ind0_rdy,
  output logic             ind1_ena,
  output logic [Width-1:0] ind1_gray,
  output logic [Width-1:0] ind1_bin,
  input  logic             ind1_rdy,
  output logic             counter_increment_ena,
  output logic             counter_decrement_ena,
  output logic             counter_write_bin_ena,
  output logic             counter_write_gray_ena,
  output logic [Width-1:0] counter_write_bin_v,
  output logic [Width-1:0] counter_write_gray_v,
  input  logic             counter_increment_rdy,
  input  logic             counter_decrement_rdy,
  input  logic             counter_write_bin_rdy,
  input  logic             counter_write_gray_rdy,
  input  logic             counter_read_gray_rdy,
  input  logic             counter_read_bin_rdy,
  input  logic [Width-1:0] counter_read_gray,
  input  logic [Width-1:0] counter_read_bin
);

  typedef enum logic [1:0] {StIdle, StIssue, StReport, StInd} state_e;

  localparam logic [1:0] OpInc    = 2'd0;
  localparam logic [1:0] OpDec    = 2'd1;
  localparam logic [1:0] OpWrBin  = 2'd2;
  localparam logic [1:0] OpWrGray = 2'd3;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q, prio_d;

  logic [1:0]       op_q     [2][2];
  logic [Width-1:0] v_q      [2][2];
  logic [1:0]       cnt_q    [2];
  logic [1:0]       rd_ptr_q, wr_ptr_q;
  logic [1:0]       in_op    [2];
  logic [Width-1:0] in_v     [2];
  logic [1:0]       head_op  [2];
  logic [Width-1:0] head_v   [2];

  logic [1:0] enq, deq, elig, ind_rdy_vec;
  logic [3:0] op_rdy_vec;
  logic [1:0] issue_op;
  logic [Width-1:0] issue_v;
  logic       capture, release_ind;

  logic [1:0]       ind_ena_q;
  logic [Width-1:0] ind_gray_q [2];
  logic [Width-1:0] ind_bin_q  [2];

  assign in_op[0] = req0_op;
  assign in_op[1] = req1_op;
  assign in_v[0]  = req0_v;
  assign in_v[1]  = req1_v;

  // Space flag comes straight from the registered count; no same-cycle bypass.
  assign req0_rdy = (cnt_q[0] != 2'd2);
  assign req1_rdy = (cnt_q[1] != 2'd2);
  assign enq      = {req1_ena & req1_rdy, req0_ena & req0_rdy};

  assign op_rdy_vec  = {counter_write_gray_rdy, counter_write_bin_rdy,
                        counter_decrement_rdy, counter_increment_rdy};
  assign ind_rdy_vec = {ind1_rdy, ind0_rdy};

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      head_op[r] = op_q[r][rd_ptr_q[r]];
      head_v[r]  = v_q[r][rd_ptr_q[r]];
      elig[r]    = (cnt_q[r] != 2'd0) && op_rdy_vec[head_op[r]];
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int r = 0; r < 2; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (enq[r]) wr_ptr_q[r] <= ~wr_ptr_q[r];
        if (deq[r]) rd_ptr_q[r] <= ~rd_ptr_q[r];
        if (enq[r] && !deq[r])      cnt_q[r] <= cnt_q[r] + 2'd1;
        else if (!enq[r] && deq[r]) cnt_q[r] <= cnt_q[r] - 2'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int r = 0; r < 2; r++) begin
      if (enq[r]) begin
        op_q[r][wr_ptr_q[r]] <= in_op[r];
        v_q[r][wr_ptr_q[r]]  <= in_v[r];
      end
    end
  end

  assign issue_op = head_op[owner_q];
  assign issue_v  = head_v[owner_q];

  always_comb begin
    state_d                = state_q;
    owner_d                = owner_q;
    prio_d                 = prio_q;
    deq                    = '0;
    capture                = 1'b0;
    release_ind            = 1'b0;
    counter_increment_ena  = 1'b0;
    counter_decrement_ena  = 1'b0;
    counter_write_bin_ena  = 1'b0;
    counter_write_gray_ena = 1'b0;
    counter_write_bin_v    = '0;
    counter_write_gray_v   = '0;
    unique case (state_q)
      StIdle: begin
        if (elig != 2'b00) begin
          owner_d = (elig == 2'b11) ? prio_q : elig[1];
          prio_d  = ~owner_d;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Guard may have dropped since the grant; hold until it returns.
        if (op_rdy_vec[issue_op]) begin
          deq[owner_q] = 1'b1;
          state_d      = StReport;
          unique case (issue_op)
            OpInc:    counter_increment_ena = 1'b1;
            OpDec:    counter_decrement_ena = 1'b1;
            OpWrBin: begin
              counter_write_bin_ena = 1'b1;
              counter_write_bin_v   = issue_v;
            end
            OpWrGray: begin
              counter_write_gray_ena = 1'b1;
              counter_write_gray_v   = issue_v;
            end
          endcase
        end
      end
      StReport: begin
        if (counter_read_gray_rdy && counter_read_bin_rdy) begin
          capture = 1'b1;
          state_d = StInd;
        end
      end
      StInd: begin
        if (ind_rdy_vec[owner_q]) begin
          release_ind = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      ind_ena_q <= '0;
      for (int r = 0; r < 2; r++) begin
        ind_gray_q[r] <= '0;
        ind_bin_q[r]  <= '0;
      end
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      if (capture) begin
        ind_ena_q[owner_q]  <= 1'b1;
        ind_gray_q[owner_q] <= counter_read_gray;
        ind_bin_q[owner_q]  <= counter_read_bin;
      end
      if (release_ind) ind_ena_q[owner_q] <= 1'b0;
    end
  end

  assign ind0_ena  = ind_ena_q[0];
  assign ind1_ena  = ind_ena_q[1];
  assign ind0_gray = ind_gray_q[0];
  assign ind0_bin  = ind_bin_q[0];
  assign ind1_gray = ind_gray_q[1];
  assign ind1_bin  = ind_bin_q[1];

endmodule

// File: tb/tb_gray_counter_arbiter.sv
// Bench for gray_counter_arbiter: behavioural gray counter, result scoreboard,
// table-driven single-requester commands and directed arbitration/reset sequences.
module tb_gray_counter_arbiter;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       req0_ena, req1_ena, req0_rdy, req1_rdy;
  logic [1:0] req0_op, req1_op;
  logic [3:0] req0_v, req1_v;
  logic       ind0_ena, ind1_ena, ind0_rdy, ind1_rdy;
  logic [3:0] ind0_gray, ind0_bin, ind1_gray, ind1_bin;
  logic       inc_ena, dec_ena, wb_ena, wg_ena;
  logic [3:0] wb_v, wg_v;
  logic       inc_rdy, dec_rdy, wb_rdy, wg_rdy, rd_rdy;
  logic [3:0] read_gray, read_bin;

  always #5 CLK = ~CLK;

  gray_counter_arbiter #(.Width(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .req0_ena(req0_ena), .req0_op(req0_op), .req0_v(req0_v), .req0_rdy(req0_rdy),
    .req1_ena(req1_ena), .req1_op(req1_op), .req1_v(req1_v), .req1_rdy(req1_rdy),
    .ind0_ena(ind0_ena), .ind0_gray(ind0_gray), .ind0_bin(ind0_bin), .ind0_rdy(ind0_rdy),
    .ind1_ena(ind1_ena), .ind1_gray(ind1_gray), .ind1_bin(ind1_bin), .ind1_rdy(ind1_rdy),
    .counter_increment_ena(inc_ena), .counter_decrement_ena(dec_ena),
    .counter_write_bin_ena(wb_ena), .counter_write_gray_ena(wg_ena),
    .counter_write_bin_v(wb_v), .counter_write_gray_v(wg_v),
    .counter_increment_rdy(inc_rdy), .counter_decrement_rdy(dec_rdy),
    .counter_write_bin_rdy(wb_rdy), .counter_write_gray_rdy(wg_rdy),
    .counter_read_gray_rdy(rd_rdy), .counter_read_bin_rdy(rd_rdy),
    .counter_read_gray(read_gray), .counter_read_bin(read_bin)
  );

  // Behavioural stand-in for the shared GrayCounter.
  logic [3:0] bin_m;
  logic       ctr_clear;

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always @(posedge CLK) begin
    if (ctr_clear)    bin_m <= 4'd0;
    else if (inc_ena) bin_m <= bin_m + 4'd1;
    else if (dec_ena) bin_m <= bin_m - 4'd1;
    else if (wb_ena)  bin_m <= wb_v;
    else if (wg_ena)  bin_m <= g2b(wg_v);
  end

  assign read_bin  = bin_m;
  assign read_gray = bin_m ^ (bin_m >> 1);

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       who;
    logic [3:0] gray;
    logic [3:0] bin;
  } exp_t;

  exp_t sb[$];

  task automatic push(input logic who, input logic [3:0] g, input logic [3:0] b);
    exp_t e;
    e.who = who; e.gray = g; e.bin = b;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic who, input logic [3:0] g, input logic [3:0] b);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_ind actual=ind%0d gray=%0h bin=%0h required=none", who, g, b);
    end else begin
      e = sb.pop_front();
      check("ind_result", {23'd0, who, g, b}, {23'd0, e.who, e.gray, e.bin});
    end
  endtask

  // Monitor: scoreboard pops on indication handshakes plus counter-strobe invariants.
  int cyc = 0;
  int last_ena = -100;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    logic [3:0] ctr_vec;
    if (nRST === 1'b1) begin
      ctr_vec = {wg_ena, wb_ena, dec_ena, inc_ena};
      if (ctr_vec != 4'd0) begin
        check("ena_onehot", $countones(ctr_vec), 1);
        check("ena_guard", {28'd0, ctr_vec & {wg_rdy, wb_rdy, dec_rdy, inc_rdy}}, {28'd0, ctr_vec});
        check("ena_spacing", {31'd0, (cyc - last_ena) >= 4}, 32'd1);
        last_ena = cyc;
      end
      if (ind0_ena && ind1_ena) check("ind_exclusive", 32'd3, 32'd1);
      if (ind0_ena && ind0_rdy) sb_pop(1'b0, ind0_gray, ind0_bin);
      if (ind1_ena && ind1_rdy) sb_pop(1'b1, ind1_gray, ind1_bin);
    end
  end

  task automatic do_reset(input logic clr);
    nRST = 1'b0;
    ctr_clear = clr;
    @(posedge CLK); #1;
    nRST = 1'b1;
    ctr_clear = 1'b0;
    sb.delete();
    check("reset_state",
          {3'd0, ind0_ena, ind1_ena, inc_ena | dec_ena | wb_ena | wg_ena, req0_rdy, req1_rdy,
           ind0_gray, ind0_bin, ind1_gray, ind1_bin, wb_v, wg_v},
          {3'd0, 5'b00011, 24'd0});
  endtask

  task automatic enq(input int r, input logic [1:0] op, input logic [3:0] v);
    int n = 0;
    while (((r == 0) ? req0_rdy : req1_rdy) == 1'b0 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL enq_timeout actual=rdy_low required=rdy_high req%0d", r);
    end
    if (r == 0) begin req0_ena = 1'b1; req0_op = op; req0_v = v; end
    else        begin req1_ena = 1'b1; req1_op = op; req1_v = v; end
    @(posedge CLK); #1;
    req0_ena = 1'b0;
    req1_ena = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (2) begin @(posedge CLK); #1; end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] v;
    logic [3:0] gray;
    logic [3:0] bin;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n;
    tbl[0] = '{op: 2'd2, v: 4'd15, gray: 4'b1000, bin: 4'd15};
    tbl[1] = '{op: 2'd0, v: 4'd5,  gray: 4'b0000, bin: 4'd0};
    tbl[2] = '{op: 2'd1, v: 4'd10, gray: 4'b1000, bin: 4'd15};
    tbl[3] = '{op: 2'd3, v: 4'd6,  gray: 4'b0110, bin: 4'd4};
    tbl[4] = '{op: 2'd1, v: 4'd0,  gray: 4'b0010, bin: 4'd3};
    tbl[5] = '{op: 2'd3, v: 4'd15, gray: 4'b1111, bin: 4'd10};
    tbl[6] = '{op: 2'd0, v: 4'd0,  gray: 4'b1110, bin: 4'd11};
    tbl[7] = '{op: 2'd2, v: 4'd7,  gray: 4'b0100, bin: 4'd7};

    req0_ena = 0; req1_ena = 0; req0_op = 0; req1_op = 0; req0_v = 0; req1_v = 0;
    ind0_rdy = 1; ind1_rdy = 1;
    inc_rdy = 1; dec_rdy = 1; wb_rdy = 1; wg_rdy = 1; rd_rdy = 1;
    ctr_clear = 1;
    repeat (2) @(posedge CLK);
    #1;
    do_reset(1'b1);

    // Three back-to-back increments; the third stalls on a full buffer.
    push(0, 4'b0001, 4'd1);
    push(0, 4'b0011, 4'd2);
    push(0, 4'b0010, 4'd3);
    enq(0, 2'd0, 4'd0);
    enq(0, 2'd0, 4'd0);
    check("rdy_full", {31'd0, req0_rdy}, 32'd0);
    enq(0, 2'd0, 4'd0);
    wait_done();

    // Simultaneous requests after reset: prio=0 serves req0 first.
    do_reset(1'b1);
    push(0, 4'b0001, 4'd1);
    push(1, 4'b1101, 4'd9);
    req0_ena = 1; req0_op = 2'd0; req0_v = 4'd0;
    req1_ena = 1; req1_op = 2'd2; req1_v = 4'd9;
    @(posedge CLK); #1;
    req0_ena = 0; req1_ena = 0;
    wait_done();

    // Table of single commands, including wrap in both directions.
    for (int i = 0; i < 8; i++) begin
      push(0, tbl[i].gray, tbl[i].bin);
      enq(0, tbl[i].op, tbl[i].v);
      wait_done();
    end

    // Indication back-pressure holds data and blocks req1's queued command.
    ind0_rdy = 0;
    push(0, 4'b1100, 4'd8);
    enq(0, 2'd0, 4'd0);
    n = 0;
    while (!ind0_ena && n < 50) begin @(posedge CLK); #1; n++; end
    push(1, 4'b0100, 4'd7);
    enq(1, 2'd1, 4'd0);
    for (int k = 0; k < 5; k++) begin
      check("hold_stable",
            {21'd0, ind0_ena, ind0_gray, ind0_bin, inc_ena | dec_ena | wb_ena | wg_ena, ind1_ena},
            {21'd0, 1'b1, 4'b1100, 4'd8, 1'b0, 1'b0});
      @(posedge CLK); #1;
    end
    ind0_rdy = 1;
    wait_done();

    // Blocked decrement guard: req1 overtakes despite prio=0.
    dec_rdy = 0;
    push(1, 4'b1100, 4'd8);
    push(0, 4'b0100, 4'd7);
    req0_ena = 1; req0_op = 2'd1; req0_v = 4'd0;
    req1_ena = 1; req1_op = 2'd0; req1_v = 4'd0;
    @(posedge CLK); #1;
    req0_ena = 0; req1_ena = 0;
    n = 0;
    while (sb.size() > 1 && n < 100) begin @(posedge CLK); #1; n++; end
    repeat (5) begin @(posedge CLK); #1; end
    check("dec_held", sb.size(), 1);
    dec_rdy = 1;
    wait_done();

    // Reset while stuck in REPORT with two commands buffered; counter keeps its value.
    rd_rdy = 0;
    enq(0, 2'd0, 4'd0);
    enq(0, 2'd0, 4'd0);
    enq(0, 2'd0, 4'd0);
    repeat (2) begin @(posedge CLK); #1; end
    do_reset(1'b0);
    rd_rdy = 1;
    push(0, 4'b1101, 4'd9);
    enq(0, 2'd0, 4'd0);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gray_counter_arbiter.md
Name: gray_counter_arbiter

Overview:
Shares one GrayCounter(width) instance between two independent requesters. Each requester posts counter commands (increment, decrement, writeBin, writeGray) into a private 2-entry buffer. A round-robin scheduler issues one command at a time to the counter's method interface. After each command it returns the updated gray and binary values to the issuing requester as an indication. The block sits between the P2M command decode and the counter, replacing the direct request-to-counter wiring.

Parameters:
width, 4, counter width; width of all value fields.

Ports:
CLK  in  1  clock; all state updates on rising edge.
nRST  in  1  synchronous active-low reset, sampled on CLK rising edge.
req0__ENA / req1__ENA  in  1  command enqueue strobe, per requester.
req0$op / req1$op  in  2  command: 0 increment, 1 decrement, 2 writeBin, 3 writeGray.
req0$v / req1$v  in  width  write value; ignored for op 0/1.
req0__RDY / req1__RDY  out  1  buffer has space.
ind0__ENA / ind1__ENA  out  1  result valid for that requester.
ind0$gray / ind1$gray  out  width  counter gray value after the command.
ind0$bin / ind1$bin  out  width  counter binary value after the command.
ind0__RDY / ind1__RDY  in  1  requester accepts result.
counter$increment__ENA, counter$decrement__ENA, counter$writeBin__ENA, counter$writeGray__ENA  out  1  counter method strobes.
counter$writeBin$v, counter$writeGray$v  out  width  method arguments.
counter$increment__RDY, counter$decrement__RDY, counter$writeBin__RDY, counter$writeGray__RDY, counter$readGray__RDY, counter$readBin__RDY  in  1  counter guards.
counter$readGray, counter$readBin  in  width  counter values.

Behaviour:
- Reset (nRST=0 at an edge):
  - buffers empty; FSM=IDLE; prio=0.
  - All __ENA outputs 0; ind*$gray/$bin and counter $v outputs 0.
  - Applies from any state, including mid-REPORT; a pending indication is dropped.
- Buffers:
  - Per requester: 2-entry FIFO of {op, v}.
  - reqN__RDY = (count<2), registered from current count; no bypass.
  - Enqueue occurs when reqN__ENA && reqN__RDY.
  - Enqueue and dequeue in the same cycle: count is unchanged.
- FSM IDLE:
  - Requester N is eligible if its buffer is non-empty and the counter __RDY for its head op is 1.
  - Both eligible: grant prio. One eligible: grant it. None: stay in IDLE.
  - On grant: latch owner; prio <= ~owner; go to ISSUE.
- FSM ISSUE (1 cycle):
  - Assert exactly one counter method __ENA, selected by the latched head op; drive the matching $v from the head.
  - Dequeue the owner's head entry. Go to REPORT.
  - The head op's __RDY was checked in IDLE; if it has dropped by ISSUE, stay in ISSUE with no ENA until it returns.
- FSM REPORT:
  - Wait until counter$readGray__RDY && counter$readBin__RDY (counter already updated).
  - Capture readGray/readBin into the owner's ind registers. Assert ind<owner>__ENA from the next cycle; hold ENA and data stable until ind<owner>__RDY=1.
  - On that handshake edge: ENA<=0, go to IDLE.
  - The other requester's ind__ENA stays 0 throughout.
- Timing:
  - Minimum grant-to-grant spacing is 4 cycles: IDLE, ISSUE, REPORT capture, ind handshake.
  - Counter method ENAs are never asserted outside ISSUE and are one-hot.
- Width rules: values pass through unmodified; counter wrap-around is the counter's behaviour, and results reflect it.

Test Plan:
- Reset, req0 increment x3 back-to-back (second accepted, third stalls on req0__RDY until a dequeue) → ind0 results bin 1,2,3 with gray 0001,0011,0010; counter$increment__ENA pulses ≥4 cycles apart.
- Same cycle: req0 increment, req1 writeBin v=9 (prio=0) → ind0 bin1/gray0001 first, then ind1 bin9/gray1101.
- req0 writeBin 15 then increment → ind0 bin0/gray0000; then decrement → bin15/gray1000.
- ind0__RDY held 0 for 5 cycles during REPORT → ind0__ENA and data stable; no counter ENA; req1 queued command not issued until the handshake.
- counter$decrement__RDY=0, req0 head=decrement, req1 head=increment, prio=0 → req1 granted; req0 is granted after decrement__RDY rises.
- nRST=0 during REPORT with 2 entries buffered → next cycle all ENA 0, req0__RDY=req1__RDY=1; subsequent increment yields ind bin = counter value +1.
